// File: rtl/xif_fpu_pkg.sv
// Shared types and constants for the core-side CORE-V-XIF FPU link.
// Used by the issuer, its ID table and the FPU-side wrapper.
//   X_ID_WIDTH_DEF : default transaction ID width
//   WB_RD_W        : integer register-file address width
//   xif_id_t       : transaction ID at the default width
//   id_entry_t     : per-ID table record {busy, rd}
//   iss_state_t    : issue register occupancy
package xif_fpu_pkg;

  localparam int X_ID_WIDTH_DEF = 4;
  localparam int WB_RD_W        = 5;

  typedef logic [X_ID_WIDTH_DEF-1:0] xif_id_t;

  typedef struct packed {
    logic               busy;
    logic [WB_RD_W-1:0] rd;
  } id_entry_t;

  typedef enum logic {
    ISS_EMPTY = 1'b0,
    ISS_HELD  = 1'b1
  } iss_state_t;

endpackage

// File: rtl/xif_fpu_issuer_id_table.sv
// Outstanding-transaction table for the FPU issuer.
// Holds one busy bit and one destination register per transaction ID.
//   ck, rst, flush          : clock, synchronous reset, kill all entries
//   alloc_valid/id/rd       : mark an ID busy and record its destination
//   ret_valid/id/we         : returning result; ret_hit says the ID was busy
//   ret_rsp                 : registered one cycle after a retirement:
//                             busy = retired with a write request, rd = stored rd
//   lookup_id/lookup_busy   : busy lookup used for the next ID to allocate
//   count                   : registered number of busy IDs
module xif_id_table
  import xif_fpu_pkg::*;
#(
  parameter int ID_W            = X_ID_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 ck,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 alloc_valid,
  input  logic [ID_W-1:0]                      alloc_id,
  input  logic [WB_RD_W-1:0]                   alloc_rd,
  input  logic                                 ret_valid,
  input  logic [ID_W-1:0]                      ret_id,
  input  logic                                 ret_we,
  output logic                                 ret_hit,
  output id_entry_t                            ret_rsp,
  input  logic [ID_W-1:0]                      lookup_id,
  output logic                                 lookup_busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count
);

  localparam int DEPTH = 2 ** ID_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DEPTH-1:0]   busy_reg;
  logic [DEPTH-1:0]   busy_set;
  logic [DEPTH-1:0]   busy_clr;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic               retire;
  logic               wr_req_reg;
  logic [WB_RD_W-1:0] rd_rdata_reg;

  // Destination registers live in a plain array with a registered read;
  // the read lines up with the one-cycle writeback latency.
  logic [WB_RD_W-1:0] rd_mem [DEPTH];

  assign ret_hit     = ret_valid && busy_reg[ret_id];
  assign retire      = ret_hit && !flush;
  assign lookup_busy = busy_reg[lookup_id];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign busy_set[gi] = alloc_valid && (alloc_id == ID_W'(gi));
      assign busy_clr[gi] = retire && (ret_id == ID_W'(gi));
    end
  endgenerate

  // Allocation never targets a busy ID, so set and clear cannot collide.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (alloc_valid && !retire) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!alloc_valid && retire) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge ck) begin
    if (rst || flush) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg | busy_set) & ~busy_clr;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      count_reg  <= '0;
      wr_req_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_req_reg <= retire && ret_we;
    end
  end

  always_ff @(posedge ck) begin
    if (alloc_valid) begin
      rd_mem[alloc_id] <= alloc_rd;
    end
    rd_rdata_reg <= rd_mem[ret_id];
  end

  assign ret_rsp.busy = wr_req_reg;
  assign ret_rsp.rd   = rd_rdata_reg;
  assign count        = count_reg;

endmodule

// File: rtl/xif_fpu_issuer.sv
// Core-side initiator for the CORE-V-XIF style FPU coprocessor link.
// Accepts FP instructions from the integer pipeline, tags each with a
// transaction ID, holds it in a single-entry issue register until the FPU
// takes it, matches returning results by ID and drives integer writeback.
//   ck, rst            : clock, synchronous active-high reset
//   instr_*, rs1_data,
//   rd_addr            : instruction intake (valid/ready)
//   flush              : kill all in-flight work
//   issue_*            : held instruction towards the FPU (valid/ready)
//   result_*           : FPU results, matched by result_id
//   wb_*               : one-cycle integer register writeback
//   outstanding_cnt    : number of busy IDs
//   stale_cnt          : saturating count of results for non-busy IDs
//   timeout_err        : sticky flag, no retirement for RESULT_TIMEOUT cycles
module xif_fpu_issuer
  import xif_fpu_pkg::*;
#(
  parameter int X_ID_WIDTH      = X_ID_WIDTH_DEF,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int RESULT_TIMEOUT  = 64
) (
  input  logic                                 ck,
  input  logic                                 rst,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [31:0]                          instr,
  input  logic [XLEN-1:0]                      rs1_data,
  input  logic [WB_RD_W-1:0]                   rd_addr,
  input  logic                                 flush,
  output logic                                 issue_valid,
  input  logic                                 issue_ready,
  output logic [31:0]                          issue_instr,
  output logic [X_ID_WIDTH-1:0]                issue_id,
  output logic [XLEN-1:0]                      issue_rs1,
  input  logic                                 result_valid,
  input  logic [X_ID_WIDTH-1:0]                result_id,
  input  logic [XLEN-1:0]                      result_data,
  input  logic                                 result_we,
  output logic                                 wb_valid,
  output logic [WB_RD_W-1:0]                   wb_rd,
  output logic [XLEN-1:0]                      wb_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic [7:0]                           stale_cnt,
  output logic                                 timeout_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int AGE_W = $clog2(RESULT_TIMEOUT + 1);

  iss_state_t            state_reg;
  iss_state_t            state_next;
  logic [X_ID_WIDTH-1:0] next_id_reg;
  logic [31:0]           issue_instr_reg;
  logic [X_ID_WIDTH-1:0] issue_id_reg;
  logic [XLEN-1:0]       issue_rs1_reg;
  logic [XLEN-1:0]       wb_data_reg;
  logic [7:0]            stale_cnt_reg;
  logic [AGE_W-1:0]      age_reg;
  logic [AGE_W-1:0]      age_next;
  logic                  timeout_reg;
  logic                  timeout_next;

  logic                  accept;
  logic                  handshake;
  logic                  next_busy;
  logic                  ret_hit;
  logic                  retire;
  id_entry_t             ret_rsp;
  logic [CNT_W-1:0]      count;

  xif_id_table #(
    .ID_W            (X_ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_id_table (
    .ck          (ck),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (accept),
    .alloc_id    (next_id_reg),
    .alloc_rd    (rd_addr),
    .ret_valid   (result_valid),
    .ret_id      (result_id),
    .ret_we      (result_we),
    .ret_hit     (ret_hit),
    .ret_rsp     (ret_rsp),
    .lookup_id   (next_id_reg),
    .lookup_busy (next_busy),
    .count       (count)
  );

  // A new instruction may enter while the held one leaves in the same
  // cycle; the wrapped ID must be free before it is reused.
  assign instr_ready = !rst && !flush
                     && (state_reg == ISS_EMPTY || issue_ready)
                     && (count < CNT_W'(MAX_OUTSTANDING))
                     && !next_busy;
  assign accept      = instr_valid && instr_ready;
  assign handshake   = (state_reg == ISS_HELD) && issue_ready;
  assign retire      = ret_hit && !flush;

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ISS_EMPTY;
    end else if (accept) begin
      state_next = ISS_HELD;
    end else if (handshake) begin
      state_next = ISS_EMPTY;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg       <= ISS_EMPTY;
      next_id_reg     <= '0;
      issue_instr_reg <= '0;
      issue_id_reg    <= '0;
      issue_rs1_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        issue_instr_reg <= instr;
        issue_id_reg    <= next_id_reg;
        issue_rs1_reg   <= rs1_data;
        next_id_reg     <= next_id_reg + X_ID_WIDTH'(1);
      end
    end
  end

  // Age runs only while something is outstanding and nothing retires;
  // it saturates so the sticky flag needs no extra state.
  always_comb begin
    age_next     = age_reg;
    timeout_next = timeout_reg;
    if (flush) begin
      age_next     = '0;
      timeout_next = 1'b0;
    end else begin
      if (retire || count == '0) begin
        age_next = '0;
      end else if (age_reg != AGE_W'(RESULT_TIMEOUT)) begin
        age_next = age_reg + AGE_W'(1);
      end
      if (age_next == AGE_W'(RESULT_TIMEOUT)) begin
        timeout_next = 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      age_reg       <= '0;
      timeout_reg   <= 1'b0;
      stale_cnt_reg <= '0;
      wb_data_reg   <= '0;
    end else begin
      age_reg     <= age_next;
      timeout_reg <= timeout_next;
      if (result_valid && !ret_hit && stale_cnt_reg != 8'hFF) begin
        stale_cnt_reg <= stale_cnt_reg + 8'd1;
      end
      if (retire) begin
        wb_data_reg <= result_data;
      end
    end
  end

  // x0 writes are suppressed here, once the stored rd has been read out.
  assign wb_valid        = ret_rsp.busy && (ret_rsp.rd != '0);
  assign wb_rd           = wb_valid ? ret_rsp.rd : '0;
  assign wb_data         = wb_data_reg;
  assign issue_valid     = (state_reg == ISS_HELD);
  assign issue_instr     = issue_instr_reg;
  assign issue_id        = issue_id_reg;
  assign issue_rs1       = issue_rs1_reg;
  assign outstanding_cnt = count;
  assign stale_cnt       = stale_cnt_reg;
  assign timeout_err     = timeout_reg;

endmodule

// File: tb/tb_xif_fpu_issuer.sv
module tb_xif_fpu_issuer;
  import xif_fpu_pkg::*;

  localparam int IDW  = 4;
  localparam int XLEN = 32;
  localparam int MAXO = 8;
  localparam int TMO  = 64;

  logic            ck = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [4:0]      rd_addr = '0;
  logic            flush = 1'b0;
  logic            issue_valid;
  logic            issue_ready = 1'b0;
  logic [31:0]     issue_instr;
  logic [IDW-1:0]  issue_id;
  logic [XLEN-1:0] issue_rs1;
  logic            result_valid = 1'b0;
  logic [IDW-1:0]  result_id = '0;
  logic [XLEN-1:0] result_data = '0;
  logic            result_we = 1'b0;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [3:0]      outstanding_cnt;
  logic [7:0]      stale_cnt;
  logic            timeout_err;

  xif_fpu_issuer #(
    .X_ID_WIDTH(IDW), .XLEN(XLEN), .MAX_OUTSTANDING(MAXO), .RESULT_TIMEOUT(TMO)
  ) dut (
    .ck(ck), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_data(rs1_data), .rd_addr(rd_addr), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs1(issue_rs1),
    .result_valid(result_valid), .result_id(result_id),
    .result_data(result_data), .result_we(result_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .outstanding_cnt(outstanding_cnt), .stale_cnt(stale_cnt),
    .timeout_err(timeout_err)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected writebacks pushed when a result retires a live ID.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t        sb_q[$];
  wb_t        sb_e;
  logic       busy_m[16];
  logic [4:0] rd_m[16];
  logic [3:0] nid_m;
  int         stale_m;
  int         wb_seen;
  logic       hit_m;

  always @(negedge ck) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
      nid_m   = '0;
      stale_m = 0;
      sb_q.delete();
    end else begin
      if (wb_valid) begin
        wb_seen++;
        if (sb_q.size() == 0) begin
          check_val("wb_unexpected", 64'd1, 64'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check_val("wb_rd", 64'(wb_rd), 64'(sb_e.rd));
          check_val("wb_data", 64'(wb_data), 64'(sb_e.data));
        end
      end
      if (result_valid) begin
        hit_m = busy_m[result_id];
        if (!hit_m) begin
          if (stale_m < 255) stale_m++;
        end else if (!flush) begin
          busy_m[result_id] = 1'b0;
          if (result_we && rd_m[result_id] != 5'd0) begin
            sb_e.rd   = rd_m[result_id];
            sb_e.data = result_data;
            sb_q.push_back(sb_e);
          end
        end
      end
      if (flush) begin
        for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
      end
      if (instr_valid && instr_ready) begin
        busy_m[nid_m] = 1'b1;
        rd_m[nid_m]   = rd_addr;
        nid_m         = nid_m + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic mid();
    @(negedge ck);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    result_valid = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic accept_one(input logic [31:0] ins, input logic [XLEN-1:0] rs1,
                            input logic [4:0] rd, input logic [3:0] exp_id);
    instr_valid = 1'b1;
    instr = ins;
    rs1_data = rs1;
    rd_addr = rd;
    mid();
    check_val("acc_ready", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    check_val("acc_issue_valid", 64'(issue_valid), 64'd1);
    check_val("acc_issue_id", 64'(issue_id), 64'(exp_id));
    check_val("acc_issue_instr", 64'(issue_instr), 64'(ins));
  endtask

  task automatic send_result(input logic [3:0] id, input logic [XLEN-1:0] data, input logic we);
    result_valid = 1'b1;
    result_id = id;
    result_data = data;
    result_we = we;
    tick();
    result_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int wb_before;

  initial begin
    wb_seen = 0;
    // ---- 1: reset state and a single operation
    do_reset();
    mid();
    check_val("rst_issue_valid", 64'(issue_valid), 64'd0);
    check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_val("rst_wb_rd", 64'(wb_rd), 64'd0);
    check_val("rst_wb_data", 64'(wb_data), 64'd0);
    check_val("rst_outstanding", 64'(outstanding_cnt), 64'd0);
    check_val("rst_stale", 64'(stale_cnt), 64'd0);
    check_val("rst_timeout", 64'(timeout_err), 64'd0);
    check_val("rst_issue_id", 64'(issue_id), 64'd0);
    check_val("rst_ready", 64'(instr_ready), 64'd1);
    tick();
    issue_ready = 1'b1;
    accept_one(32'hE0000553, 32'h0000_1234, 5'd10, 4'd0);
    check_val("t1_rs1", 64'(issue_rs1), 64'h1234);
    check_val("t1_cnt1", 64'(outstanding_cnt), 64'd1);
    tick();
    check_val("t1_issue_one_cycle", 64'(issue_valid), 64'd0);
    send_result(4'd0, 32'h3F800000, 1'b1);
    check_val("t1_wb_strobe", 64'(wb_valid), 64'd1);
    check_val("t1_cnt0", 64'(outstanding_cnt), 64'd0);
    tick();
    check_val("t1_wb_one_cycle", 64'(wb_valid), 64'd0);

    // ---- 2: FPU stall holds the issue register
    issue_ready = 1'b0;
    accept_one(32'h00A5F053, 32'h55, 5'd1, 4'd1);
    instr_valid = 1'b1;
    instr = 32'h10B7F0D3;
    rs1_data = 32'h66;
    rd_addr = 5'd2;
    for (int i = 0; i < 5; i++) begin
      mid();
      check_val("t2_stall_valid", 64'(issue_valid), 64'd1);
      check_val("t2_stall_id", 64'(issue_id), 64'd1);
      check_val("t2_stall_instr", 64'(issue_instr), 64'h00A5F053);
      check_val("t2_stall_rs1", 64'(issue_rs1), 64'h55);
      check_val("t2_stall_ready", 64'(instr_ready), 64'd0);
      tick();
    end
    issue_ready = 1'b1;
    mid();
    check_val("t2_release_ready", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    check_val("t2_nobubble_valid", 64'(issue_valid), 64'd1);
    check_val("t2_nobubble_id", 64'(issue_id), 64'd2);
    check_val("t2_nobubble_instr", 64'(issue_instr), 64'h10B7F0D3);
    tick();
    check_val("t2_empty", 64'(issue_valid), 64'd0);
    check_val("t2_cnt2", 64'(outstanding_cnt), 64'd2);
    send_result(4'd1, 32'h1111, 1'b0);
    send_result(4'd2, 32'hDEAD, 1'b1);
    check_val("t2_cnt0", 64'(outstanding_cnt), 64'd0);
    tick();

    // ---- 3: outstanding limit and ID wrap
    check_val("t3_sb_drained", 64'(sb_q.size()), 64'd0);
    do_reset();
    issue_ready = 1'b1;
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = 32'h100 + i;
      rd_addr = 5'(i + 1);
      mid();
      check_val("t3_fill_ready", 64'(instr_ready), 64'd1);
      tick();
    end
    rd_addr = 5'd9;
    mid();
    check_val("t3_limit_cnt", 64'(outstanding_cnt), 64'd8);
    check_val("t3_limit_ready", 64'(instr_ready), 64'd0);
    tick();
    send_result(4'd3, 32'h3333, 1'b1);
    mid();
    check_val("t3_after_retire_ready", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    check_val("t3_id8", 64'(issue_id), 64'd8);
    check_val("t3_cnt8", 64'(outstanding_cnt), 64'd8);
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i != 3) send_result(4'(i), 32'h0, 1'b0);
    end
    check_val("t3_cnt1", 64'(outstanding_cnt), 64'd1);
    instr_valid = 1'b1;
    for (int i = 9; i < 16; i++) begin
      rd_addr = 5'(i);
      mid();
      check_val("t3_hi_ready", 64'(instr_ready), 64'd1);
      tick();
    end
    instr_valid = 1'b0;
    check_val("t3_id15", 64'(issue_id), 64'd15);
    tick();
    for (int i = 9; i < 16; i++) send_result(4'(i), 32'h0, 1'b0);
    instr_valid = 1'b1;
    rd_addr = 5'd20;
    mid();
    check_val("t3_wrap_cnt", 64'(outstanding_cnt), 64'd1);
    check_val("t3_wrap_stall", 64'(instr_ready), 64'd0);
    tick();
    tick();
    mid();
    check_val("t3_wrap_stall2", 64'(instr_ready), 64'd0);
    tick();
    send_result(4'd0, 32'h0000_00AB, 1'b1);
    mid();
    check_val("t3_wrap_free", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    check_val("t3_wrap_id0", 64'(issue_id), 64'd0);
    tick();
    send_result(4'd0, 32'h0, 1'b0);
    tick();

    // ---- 4: out-of-order retirement and a duplicate result
    check_val("t4_sb_drained", 64'(sb_q.size()), 64'd0);
    do_reset();
    issue_ready = 1'b1;
    accept_one(32'hA0000001, 32'h1, 5'd5, 4'd0);
    accept_one(32'hA0000002, 32'h2, 5'd6, 4'd1);
    accept_one(32'hA0000003, 32'h3, 5'd7, 4'd2);
    tick();
    wb_before = wb_seen;
    send_result(4'd2, 32'hD2D2_0002, 1'b1);
    send_result(4'd0, 32'hD0D0_0000, 1'b1);
    send_result(4'd1, 32'hD1D1_0001, 1'b1);
    send_result(4'd1, 32'h7777_7777, 1'b1);
    tick();
    check_val("t4_wb_count", 64'(wb_seen - wb_before), 64'd3);
    check_val("t4_stale_dup", 64'(stale_cnt), 64'd1);
    check_val("t4_cnt0", 64'(outstanding_cnt), 64'd0);

    // ---- 5: flush with three outstanding and the issue register held
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = 5'(11 + i);
      instr = 32'hB000_0000 + i;
      mid();
      check_val("t5_fill_ready", 64'(instr_ready), 64'd1);
      tick();
    end
    instr_valid = 1'b0;
    issue_ready = 1'b0;
    mid();
    check_val("t5_cnt3", 64'(outstanding_cnt), 64'd3);
    check_val("t5_held", 64'(issue_valid), 64'd1);
    check_val("t5_held_id", 64'(issue_id), 64'd5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("t5_flush_valid", 64'(issue_valid), 64'd0);
    check_val("t5_flush_cnt", 64'(outstanding_cnt), 64'd0);
    wb_before = wb_seen;
    send_result(4'd4, 32'h4444, 1'b1);
    tick();
    check_val("t5_late_no_wb", 64'(wb_seen - wb_before), 64'd0);
    check_val("t5_stale", 64'(stale_cnt), 64'd2);
    issue_ready = 1'b1;
    accept_one(32'hC0000006, 32'h6, 5'd14, 4'd6);
    tick();
    send_result(4'd6, 32'h6666, 1'b0);

    // ---- 6: result timeout, flush clears it; rd=0 writes are silent
    accept_one(32'hC0000007, 32'h7, 5'd9, 4'd7);
    repeat (63) tick();
    check_val("t6_timeout_early", 64'(timeout_err), 64'd0);
    tick();
    check_val("t6_timeout_set", 64'(timeout_err), 64'd1);
    repeat (5) tick();
    check_val("t6_timeout_sticky", 64'(timeout_err), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("t6_timeout_clear", 64'(timeout_err), 64'd0);
    check_val("t6_flush_cnt", 64'(outstanding_cnt), 64'd0);
    accept_one(32'hC0000008, 32'h8, 5'd0, 4'd8);
    tick();
    wb_before = wb_seen;
    send_result(4'd8, 32'h9999, 1'b1);
    tick();
    tick();
    check_val("t6_rd0_silent", 64'(wb_seen - wb_before), 64'd0);
    check_val("t6_rd0_cnt", 64'(outstanding_cnt), 64'd0);

    check_val("end_sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("end_stale_model", 64'(stale_cnt), 64'(stale_m));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
